iter_mul_div_alu: RTL and testbench

- Parametrised next-generation ALU for the multi-cycle CPU datapath.
- Logic, shift and compare ops are single-cycle combinational.
- MULT/MULTU/DIV/DIVU run on an iterative shift-add / restoring-divide engine with a start/busy/done handshake.
- Results land in architectural hi/lo registers, which also support mthi/mtlo writes.

---
 rtl/iter_mul_div_alu.sv | 228 ++++++++++++++++++++++
 tb/tb_iter_mul_div_alu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_mul_div_alu.sv
// Iterative multiply/divide ALU: single-cycle logic, shift and compare ops,
// plus a WIDTH-iteration shift-add / restoring-divide engine feeding hi/lo.
module iter_mul_div_alu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [3:0]       ALUCtr,
   input  logic             start,
   input  logic             hiWe,
   input  logic             loWe,
   output logic [WIDTH-1:0] ALURes,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_NOR   = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLL   = 4'b1000;
   localparam logic [3:0] OP_SRL   = 4'b1001;
   localparam logic [3:0] OP_SRA   = 4'b1010;
   localparam logic [3:0] OP_MULT  = 4'b1011;
   localparam logic [3:0] OP_DIV   = 4'b1100;
   localparam logic [3:0] OP_MULTU = 4'b1101;
   localparam logic [3:0] OP_DIVU  = 4'b1110;
   localparam logic [3:0] OP_SLTU  = 4'b1111;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;      // product high half / partial remainder
   logic [WIDTH-1:0] sh_q, sh_d;        // multiplier / dividend shifting into quotient
   logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;      // raw dividend, returned in hi on divide by zero
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] alu_res;

   // Single-cycle result path
   always_comb begin
      alu_res = '0;
      case (ALUCtr)
         OP_ADD:  alu_res = in1 + in2;
         OP_SUB:  alu_res = in1 - in2;
         OP_AND:  alu_res = in1 & in2;
         OP_OR:   alu_res = in1 | in2;
         OP_XOR:  alu_res = in1 ^ in2;
         OP_NOR:  alu_res = ~(in1 | in2);
         OP_SLT:  alu_res = WIDTH'($signed(in1) < $signed(in2));
         OP_SLTU: alu_res = WIDTH'(in1 < in2);
         OP_SLL:  alu_res = in1 << in2[SHW-1:0];
         OP_SRL:  alu_res = in1 >> in2[SHW-1:0];
         OP_SRA:  alu_res = WIDTH'($signed(in1) >>> in2[SHW-1:0]);
         default: alu_res = '0;
      endcase
   end

   assign ALURes = alu_res;
   assign zero   = (in1 == in2);

   logic             launch_signed, launch_mul, launch;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] abs_a, abs_b;

   assign launch_signed = (ALUCtr == OP_MULT) || (ALUCtr == OP_DIV);
   assign launch_mul    = (ALUCtr == OP_MULT) || (ALUCtr == OP_MULTU);
   assign launch        = start && ((ALUCtr == OP_MULT) || (ALUCtr == OP_MULTU) ||
                                    (ALUCtr == OP_DIV)  || (ALUCtr == OP_DIVU));
   assign a_neg         = launch_signed && in1[WIDTH-1];
   assign b_neg         = launch_signed && in2[WIDTH-1];
   assign abs_a         = a_neg ? (WIDTH'(0) - in1) : in1;
   assign abs_b         = b_neg ? (WIDTH'(0) - in2) : in2;

   logic               run_mul;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH+1:0]   div_diff;
   logic               div_ok;
   logic [WIDTH-1:0]   acc_n, sh_n;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   hi_res, lo_res;

   // One engine iteration plus end-of-op sign correction
   always_comb begin
      run_mul   = (op_q == OP_MULT) || (op_q == OP_MULTU);
      mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
      div_shift = {acc_q, sh_q[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
      div_ok    = ~div_diff[WIDTH+1];
      if (run_mul) begin
         acc_n = mul_sum[WIDTH:1];
         sh_n  = {mul_sum[0], sh_q[WIDTH-1:1]};
      end else begin
         acc_n = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
         sh_n  = {sh_q[WIDTH-2:0], div_ok};
      end
      prod     = {acc_n, sh_n};
      prod_fix = neg_res_q ? ((2*WIDTH)'(0) - prod) : prod;
      if (run_mul) begin
         hi_res = prod_fix[2*WIDTH-1:WIDTH];
         lo_res = prod_fix[WIDTH-1:0];
      end else if (dbz_q) begin
         hi_res = dvd_q;
         lo_res = '1;
      end else begin
         hi_res = neg_rem_q ? (WIDTH'(0) - acc_n) : acc_n;
         lo_res = neg_res_q ? (WIDTH'(0) - sh_n) : sh_n;
      end
   end

   // Next-state: launch, iterate, write back; mthi/mtlo when idle
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      acc_d     = acc_q;
      sh_d      = sh_q;
      opnd_d    = opnd_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      dvd_d     = dvd_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      if (!busy_q) begin
         if (hiWe) hi_d = in1;
         if (loWe) lo_d = in1;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (launch) begin
               state_d   = S_RUN;
               cnt_d     = '0;
               op_d      = ALUCtr;
               acc_d     = '0;
               opnd_d    = launch_mul ? abs_a : abs_b;
               sh_d      = launch_mul ? abs_b : abs_a;
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               dbz_d     = (in2 == '0);
               dvd_d     = in1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            acc_d = acc_n;
            sh_d  = sh_n;
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == LAST_ITER) begin
               hi_d    = hi_res;
               lo_d    = lo_res;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         acc_q     <= '0;
         sh_q      <= '0;
         opnd_q    <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         dvd_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         sh_q      <= sh_d;
         opnd_q    <= opnd_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         dvd_q     <= dvd_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_iter_mul_div_alu.sv
// Directed self-checking bench for iter_mul_div_alu.
module tb_iter_mul_div_alu;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_NOR   = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLL   = 4'b1000;
   localparam logic [3:0] OP_SRL   = 4'b1001;
   localparam logic [3:0] OP_SRA   = 4'b1010;
   localparam logic [3:0] OP_MULT  = 4'b1011;
   localparam logic [3:0] OP_DIV   = 4'b1100;
   localparam logic [3:0] OP_MULTU = 4'b1101;
   localparam logic [3:0] OP_DIVU  = 4'b1110;
   localparam logic [3:0] OP_SLTU  = 4'b1111;

   logic        clk;
   logic        rst_n;
   logic [31:0] in1, in2;
   logic [3:0]  ALUCtr;
   logic        start, hiWe, loWe;
   logic [31:0] ALURes, hi, lo;
   logic        zero, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   iter_mul_div_alu #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .ALUCtr(ALUCtr),
      .start(start), .hiWe(hiWe), .loWe(loWe), .ALURes(ALURes), .zero(zero),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Launch a multi-cycle op; k = edges after the start edge until done is seen
   task automatic run_op(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b,
                         output int k, output logic busy0);
      ALUCtr = ctr; in1 = a; in2 = b; start = 1'b1;
      cyc();
      start = 1'b0;
      busy0 = busy;
      k = 0;
      while (!done && k < 100) begin
         cyc();
         k++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in1 = '0; in2 = '0; ALUCtr = OP_AND; start = 0; hiWe = 0; loWe = 0;
      #12;
      n_checks++;
      if ({hi, lo, busy, done} !== 66'd0) begin
         n_fail++;
         $display("FAIL reset: hi=%h lo=%h busy=%b done=%b required all zero", hi, lo, busy, done);
      end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_comb();
      logic [3:0]  ctr [13] = '{OP_ADD, OP_SRA, OP_SLT, OP_SLTU, OP_SUB, OP_AND, OP_OR,
                                OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_MULT, OP_DIVU};
      logic [31:0] va  [13] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5,
                                32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'd0, 32'd1,
                                32'h80000000, 32'd3, 32'd9};
      logic [31:0] vb  [13] = '{32'hFFFFFFFF, 32'h24, 32'd1, 32'd1, 32'd7, 32'hFF00FF00,
                                32'h0F0F0000, 32'h0F0F0F0F, 32'd0, 32'h3F, 32'd31, 32'd4, 32'd3};
      logic [31:0] ve  [13] = '{32'd6, 32'hF8000000, 32'd1, 32'd0, 32'hFFFFFFFE, 32'hF000F000,
                                32'hFFFFF0F0, 32'hF0F00F0F, 32'hFFFFFFFF, 32'h80000000,
                                32'd1, 32'd0, 32'd0};
      for (int i = 0; i < 13; i++) begin
         ALUCtr = ctr[i]; in1 = va[i]; in2 = vb[i];
         #1;
         n_checks++;
         if (ALURes !== ve[i]) begin
            n_fail++;
            $display("FAIL comb[%0d] op=%b: ALURes=%h required %h", i, ctr[i], ALURes, ve[i]);
         end
      end
      ALUCtr = OP_SLT; in1 = 32'hFFFFFFFF; in2 = 32'd1; #1;
      n_checks++;
      if (zero !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_ne: zero=%b required 0", zero);
      end
      ALUCtr = OP_SRL; in1 = 32'h1234; in2 = 32'h1234; #1;
      n_checks++;
      if (zero !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_eq: zero=%b required 1", zero);
      end
   endtask

   task automatic test_mul();
      int k; logic b0;
      run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, k, b0);
      n_checks++;
      if ({b0, k} !== {1'b1, 32'd32}) begin
         n_fail++;
         $display("FAIL mult_latency: busy=%b cycles=%0d required busy=1 cycles=32", b0, k);
      end
      n_checks++;
      if ({hi, lo, busy} !== {32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0}) begin
         n_fail++;
         $display("FAIL mult: hi=%h lo=%h busy=%b required FFFFFFFF FFFFFFEB 0", hi, lo, busy);
      end
      cyc();
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse: done=%b required 0", done);
      end
      run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, k, b0);
      n_checks++;
      if ({k, hi, lo} !== {32'd32, 32'hFFFFFFFE, 32'h00000001}) begin
         n_fail++;
         $display("FAIL multu: cycles=%0d hi=%h lo=%h required 32 FFFFFFFE 00000001", k, hi, lo);
      end
      cyc();
   endtask

   task automatic test_div();
      int k; logic b0;
      run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, k, b0);
      n_checks++;
      if ({k, hi, lo} !== {32'd32, 32'hFFFFFFFF, 32'hFFFFFFFD}) begin
         n_fail++;
         $display("FAIL div_neg: cycles=%0d hi=%h lo=%h required 32 FFFFFFFF FFFFFFFD", k, hi, lo);
      end
      run_op(OP_DIVU, 32'd100, 32'd7, k, b0);
      n_checks++;
      if ({hi, lo} !== {32'd2, 32'd14}) begin
         n_fail++;
         $display("FAIL divu: hi=%h lo=%h required 00000002 0000000e", hi, lo);
      end
      run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, k, b0);
      n_checks++;
      if ({hi, lo} !== {32'd0, 32'h80000000}) begin
         n_fail++;
         $display("FAIL div_ovf: hi=%h lo=%h required 00000000 80000000", hi, lo);
      end
      run_op(OP_DIV, 32'hFFFFFFFB, 32'd0, k, b0);
      n_checks++;
      if ({hi, lo} !== {32'hFFFFFFFB, 32'hFFFFFFFF}) begin
         n_fail++;
         $display("FAIL div_zero_s: hi=%h lo=%h required FFFFFFFB FFFFFFFF", hi, lo);
      end
      run_op(OP_DIVU, 32'd5, 32'd0, k, b0);
      n_checks++;
      if ({k, hi, lo} !== {32'd32, 32'd5, 32'hFFFFFFFF}) begin
         n_fail++;
         $display("FAIL divu_zero: cycles=%0d hi=%h lo=%h required 32 00000005 FFFFFFFF", k, hi, lo);
      end
      cyc();
   endtask

   task automatic test_busy_ignore();
      int k;
      // hi holds 5 from the preceding divide-by-zero
      ALUCtr = OP_ADD; start = 1'b1; cyc(); start = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_nonmulti: busy=%b required 0", busy);
      end
      ALUCtr = OP_MULTU; in1 = 32'd6; in2 = 32'd7; start = 1'b1;
      cyc();
      start = 1'b0; k = 0;
      repeat (3) begin cyc(); k++; end
      ALUCtr = OP_DIVU; in1 = 32'hDEAD; in2 = 32'd3; start = 1'b1; hiWe = 1'b1; loWe = 1'b1;
      cyc(); k++;
      start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
      n_checks++;
      if ({hi, lo, busy} !== {32'd5, 32'hFFFFFFFF, 1'b1}) begin
         n_fail++;
         $display("FAIL busy_we: hi=%h lo=%h busy=%b required 00000005 FFFFFFFF 1", hi, lo, busy);
      end
      while (!done && k < 100) begin cyc(); k++; end
      n_checks++;
      if ({k, hi, lo} !== {32'd32, 32'd0, 32'd42}) begin
         n_fail++;
         $display("FAIL busy_ignore: cycles=%0d hi=%h lo=%h required 32 00000000 0000002a", k, hi, lo);
      end
      cyc();
      hiWe = 1'b1; in1 = 32'hCAFE; cyc(); hiWe = 1'b0;
      n_checks++;
      if (hi !== 32'hCAFE) begin
         n_fail++;
         $display("FAIL mthi: hi=%h required 0000cafe", hi);
      end
   endtask

   task automatic test_back_to_back();
      int k; int k2; logic b0;
      run_op(OP_MULTU, 32'd3, 32'd5, k, b0);
      n_checks++;
      if ({k, hi, lo} !== {32'd32, 32'd0, 32'd15}) begin
         n_fail++;
         $display("FAIL b2b_first: cycles=%0d hi=%h lo=%h required 32 00000000 0000000f", k, hi, lo);
      end
      ALUCtr = OP_DIVU; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
      cyc();
      start = 1'b0; k2 = 1;
      n_checks++;
      if ({busy, done} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_accept: busy=%b done=%b required 1 0", busy, done);
      end
      while (!done && k2 < 100) begin cyc(); k2++; end
      n_checks++;
      if ({k2, hi, lo} !== {32'd33, 32'd2, 32'd14}) begin
         n_fail++;
         $display("FAIL b2b_second: cycles=%0d hi=%h lo=%h required 33 00000002 0000000e", k2, hi, lo);
      end
      cyc();
   endtask

   task automatic test_reset_mid_op();
      logic seen;
      ALUCtr = OP_MULT; in1 = 32'd5; in2 = 32'd6; start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (10) cyc();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({hi, lo, busy, done} !== 66'd0) begin
         n_fail++;
         $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b required all zero", hi, lo, busy, done);
      end
      #2;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         cyc();
         if (done) seen = 1'b1;
      end
      n_checks++;
      if ({seen, busy, hi, lo} !== 66'd0) begin
         n_fail++;
         $display("FAIL reset_abort: done_seen=%b busy=%b hi=%h lo=%h required all zero", seen, busy, hi, lo);
      end
      loWe = 1'b1; in1 = 32'h1234; cyc(); loWe = 1'b0;
      n_checks++;
      if (lo !== 32'h1234) begin
         n_fail++;
         $display("FAIL mtlo: lo=%h required 00001234", lo);
      end
   endtask

   initial begin
      test_reset();
      test_comb();
      test_mul();
      test_div();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
